// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage core.
// Produces register enables (1 = advance, 0 = hold) for PC, F/D and D/E,
// and bubble (flush) lines for F/D and D/E. Resolves load-use hazards,
// PC-writing instructions and taken branches, multi-cycle vector ops that
// occupy Execute, and instruction-memory wait states.
//
// Vector occupancy FSM
//   state | meaning
//   IDLE  | Execute is free; a vector op entering Execute may start a hold
//   BUSY  | vector op still occupying Execute; vec_cnt counts remaining cycles
//
// imem wait tracking: wait_cnt counts consecutive not-ready cycles
// (saturating); imem_timeout is a sticky status flag that only reset clears.
module hazard_control_unit #(
   parameter int REG_BITS = 4,
   parameter int VEC_LAT  = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_BITS-1:0] Ra1D,
   input  logic [REG_BITS-1:0] Ra2D,
   input  logic [REG_BITS-1:0] WA3E,
   input  logic                MemtoRegE,
   input  logic                RegWriteE,
   input  logic                PCSrcD,
   input  logic                PCSrcE,
   input  logic                PCSrcM,
   input  logic                PCSrcW,
   input  logic                BranchTakenE,
   input  logic                VecStartE,
   input  logic                imem_ready,
   output logic                StallF,
   output logic                StallD,
   output logic                StallE,
   output logic                FlushD,
   output logic                FlushE,
   output logic                vec_busy,
   output logic                imem_timeout
);

   // The op's first Execute cycle is the cycle VecStartE is seen, so the
   // FSM only has to cover VEC_LAT-1 further cycles; the counter therefore
   // loads VEC_LAT-2 and the BUSY state lasts until it reaches zero.
   localparam bit            VEC_MULTI = (VEC_LAT > 1);
   localparam int            VCW       = (VEC_LAT > 2) ? $clog2(VEC_LAT - 1) : 1;
   localparam logic [VCW-1:0] VEC_LOAD = VCW'((VEC_LAT > 1) ? (VEC_LAT - 2) : 0);

   localparam int             WCW       = $clog2(TIMEOUT + 1);
   localparam logic [WCW-1:0] WAIT_MAX  = WCW'(TIMEOUT);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } vec_state_t;

   vec_state_t     state;
   vec_state_t     state_next;
   logic [VCW-1:0] vec_cnt;
   logic [VCW-1:0] vec_cnt_next;

   logic [WCW-1:0] wait_cnt;

   logic ld;
   logic pcw;
   logic hold_e;
   logic hold_d;
   logic hold_f;
   logic vec_start;

   // ------------------------------------------------------------------
   // Vector occupancy FSM
   // ------------------------------------------------------------------

   // A start that coincides with a taken branch is on the wrong path and
   // is being flushed, so it must not occupy Execute.
   assign vec_start = VecStartE & ~BranchTakenE & VEC_MULTI;

   // State and occupancy counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         vec_cnt <= '0;
      end else begin
         state   <= state_next;
         vec_cnt <= vec_cnt_next;
      end
   end

   // Next-state and counter update; VecStartE is ignored while BUSY.
   always_comb begin
      state_next   = state;
      vec_cnt_next = vec_cnt;
      case (state)
         IDLE: begin
            if (vec_start) begin
               state_next   = BUSY;
               vec_cnt_next = VEC_LOAD;
            end
         end
         BUSY: begin
            if (vec_cnt == '0) begin
               state_next = IDLE;
            end else begin
               vec_cnt_next = vec_cnt - VCW'(1);
            end
         end
         default: begin
            state_next   = IDLE;
            vec_cnt_next = '0;
         end
      endcase
   end

   assign vec_busy = (state == BUSY);

   // ------------------------------------------------------------------
   // Instruction-memory wait tracking
   // ------------------------------------------------------------------

   // Consecutive not-ready cycle counter, saturating at TIMEOUT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (imem_ready) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
         wait_cnt <= wait_cnt + WCW'(1);
      end
   end

   // Sticky timeout flag: sets on the edge where wait_cnt reaches TIMEOUT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_timeout <= 1'b0;
      end else if (!imem_ready && (wait_cnt == WAIT_LAST)) begin
         imem_timeout <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Hazard terms and stage controls
   // ------------------------------------------------------------------

   // Hazard detection and hold/flush resolution; register zero is not
   // special-cased, and rst forces every stage to advance with no bubbles.
   always_comb begin
      ld     = MemtoRegE & RegWriteE & ((WA3E == Ra1D) | (WA3E == Ra2D))
               & ~BranchTakenE;
      pcw    = PCSrcD | PCSrcE | PCSrcM;
      hold_e = vec_busy;
      hold_d = ld | hold_e;
      hold_f = ld | pcw | hold_e | ~imem_ready;

      StallE = 1'b1;
      StallD = 1'b1;
      StallF = 1'b1;
      FlushE = 1'b0;
      FlushD = 1'b0;

      if (!rst) begin
         StallE = ~hold_e;
         StallD = ~hold_d;
         StallF = ~hold_f;
         FlushE = (ld | BranchTakenE) & ~hold_e;
         FlushD = (pcw | PCSrcW | BranchTakenE | ~imem_ready) & ~hold_d;
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (REG_BITS=4, VEC_LAT=4, TIMEOUT=16).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// Checked vector: {StallF, StallD, StallE, FlushD, FlushE, vec_busy, imem_timeout}.
module tb_hazard_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] Ra1D, Ra2D, WA3E;
   logic       MemtoRegE, RegWriteE;
   logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
   logic       BranchTakenE, VecStartE, imem_ready;
   logic       StallF, StallD, StallE, FlushD, FlushE, vec_busy, imem_timeout;

   int total = 0;
   int bad   = 0;

   hazard_control_unit #(.REG_BITS(4), .VEC_LAT(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .Ra1D(Ra1D), .Ra2D(Ra2D), .WA3E(WA3E),
      .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE), .VecStartE(VecStartE), .imem_ready(imem_ready),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE),
      .vec_busy(vec_busy), .imem_timeout(imem_timeout)
   );

   always #5 clk = ~clk;

   wire [6:0] obs = {StallF, StallD, StallE, FlushD, FlushE, vec_busy, imem_timeout};

   task automatic chk(input string tag, input logic [6:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      Ra1D = 4'd0; Ra2D = 4'd0; WA3E = 4'd0;
      MemtoRegE = 1'b0; RegWriteE = 1'b0;
      PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
      BranchTakenE = 1'b0; VecStartE = 1'b0; imem_ready = 1'b1;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      imem_ready = 1'b0;               // hazard terms must be masked in reset
      MemtoRegE = 1'b1; RegWriteE = 1'b1;
      #12;
      chk("reset_outputs", 7'b111_00_00);

      // ---------------- load-use ----------------
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; Ra1D = 4'd1; Ra2D = 4'd5;
      #1 chk("loaduse_ra2", 7'b001_01_00);
      next_cycle();
      Ra2D = 4'd6;
      #1 chk("loaduse_nomatch", 7'b111_00_00);
      next_cycle();
      Ra1D = 4'd5;
      #1 chk("loaduse_ra1", 7'b001_01_00);
      next_cycle();
      RegWriteE = 1'b0;
      #1 chk("loaduse_no_regwrite", 7'b111_00_00);
      next_cycle();
      RegWriteE = 1'b1; WA3E = 4'd0; Ra1D = 4'd0; Ra2D = 4'd7;
      #1 chk("loaduse_reg0", 7'b001_01_00);

      // ---------------- branch masks load-use ----------------
      next_cycle();
      WA3E = 4'd5; Ra1D = 4'd1; Ra2D = 4'd5; BranchTakenE = 1'b1;
      #1 chk("branch_over_loaduse", 7'b111_11_00);

      // ---------------- vector op ----------------
      next_cycle();
      clear_inputs();
      VecStartE = 1'b1; BranchTakenE = 1'b1;   // wrong-path start: no occupancy
      #1 chk("vec_start_with_branch", 7'b111_11_00);
      next_cycle();
      clear_inputs();
      #1 chk("vec_not_started", 7'b111_00_00);
      next_cycle();
      VecStartE = 1'b1;
      #1 chk("vec_start_cycle", 7'b111_00_00);
      next_cycle();
      VecStartE = 1'b0; BranchTakenE = 1'b1; PCSrcE = 1'b1;
      #1 chk("vec_busy1", 7'b000_00_10);
      next_cycle();
      VecStartE = 1'b1;                        // ignored while BUSY
      #1 chk("vec_busy2", 7'b000_00_10);
      next_cycle();
      VecStartE = 1'b0;
      #1 chk("vec_busy3", 7'b000_00_10);
      next_cycle();
      #1 chk("vec_idle_again", 7'b011_11_00);
      next_cycle();
      clear_inputs();
      #1 chk("vec_stays_idle", 7'b111_00_00);

      // ---------------- reset mid-vector ----------------
      next_cycle();
      VecStartE = 1'b1;
      next_cycle();
      VecStartE = 1'b0;
      #1 chk("rstvec_busy1", 7'b000_00_10);
      next_cycle();
      #1 chk("rstvec_busy2", 7'b000_00_10);
      rst = 1'b1;
      #1 chk("rstvec_async_clear", 7'b111_00_00);
      next_cycle();
      rst = 1'b0;
      #1 chk("rstvec_after_release", 7'b111_00_00);
      next_cycle();
      VecStartE = 1'b1;
      next_cycle();
      VecStartE = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         #1 chk($sformatf("rstvec_rebusy%0d", i), 7'b000_00_10);
         next_cycle();
      end
      #1 chk("rstvec_done", 7'b111_00_00);

      // ---------------- PC writes ----------------
      next_cycle();
      PCSrcE = 1'b1;
      #1 chk("pcsrc_e", 7'b011_10_00);
      next_cycle();
      PCSrcE = 1'b0; PCSrcD = 1'b1;
      #1 chk("pcsrc_d", 7'b011_10_00);
      next_cycle();
      PCSrcD = 1'b0; PCSrcW = 1'b1;
      #1 chk("pcsrc_w_only", 7'b111_10_00);
      next_cycle();
      PCSrcW = 1'b0;
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd3; Ra1D = 4'd3; PCSrcM = 1'b1;
      #1 chk("pcsrc_m_with_loaduse", 7'b001_01_00);

      // ---------------- imem wait: 15 cycles, no timeout ----------------
      next_cycle();
      clear_inputs();
      imem_ready = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         #1 chk($sformatf("wait15_c%0d", i), 7'b011_10_00);
         next_cycle();
      end
      imem_ready = 1'b1;
      #1 chk("wait15_no_timeout", 7'b111_00_00);

      // ---------------- imem wait: 16 cycles, timeout ----------------
      next_cycle();
      imem_ready = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         #1 chk($sformatf("wait16_c%0d", i), 7'b011_10_00);
         next_cycle();
      end
      imem_ready = 1'b1;
      #1 chk("wait16_timeout_set", 7'b111_00_01);
      next_cycle();
      #1 chk("timeout_sticky", 7'b111_00_01);
      next_cycle();
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd9; Ra2D = 4'd9;
      #1 chk("timeout_no_effect_loaduse", 7'b001_01_01);
      next_cycle();
      clear_inputs();
      rst = 1'b1;
      #1 chk("timeout_cleared_by_rst", 7'b111_00_00);
      next_cycle();
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline controller for the 5-stage processor. It drives the enables of the PC register (StallF), the Fetch-Decode register (StallD) and the Decode-Execute register (StallE), plus the flush lines FlushD and FlushE.
- It resolves four conditions: load-use hazards, PC-write and branch redirects, multi-cycle vector operations occupying Execute, and instruction-memory wait states.
- It contains a vector-occupancy FSM and an imem wait/timeout counter. It sits beside the datapath and is instantiated in the processor top.

Parameters:
- REG_BITS, 4, register-address width.
- VEC_LAT, 4, Execute-stage occupancy in cycles of one vector op (legal range ≥ 1).
- TIMEOUT, 16, consecutive imem wait cycles before imem_timeout sets.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Ra1D  in  REG_BITS  source reg 1 of the instruction in Decode.
- Ra2D  in  REG_BITS  source reg 2 of the instruction in Decode.
- WA3E  in  REG_BITS  destination reg of the instruction in Execute.
- MemtoRegE  in  1  Execute instruction is a load.
- RegWriteE  in  1  Execute instruction writes the register file.
- PCSrcD, PCSrcE, PCSrcM  in  1 each  PC-writing instruction in D/E/M.
- PCSrcW  in  1  PC write occurring in Writeback.
- BranchTakenE  in  1  branch resolved taken in Execute.
- VecStartE  in  1  vector op has entered Execute this cycle.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- StallF  out  1  PC register enable (1 = load, 0 = hold).
- StallD  out  1  F/D register enable (1 = load, 0 = hold).
- StallE  out  1  D/E register enable (1 = load, 0 = hold).
- FlushD  out  1  clear F/D register (bubble).
- FlushE  out  1  clear D/E register (bubble).
- vec_busy  out  1  vector FSM is in BUSY.
- imem_timeout  out  1  sticky imem-timeout flag.

Behaviour:
- Stall* outputs are enables: 1 = advance, 0 = hold. They connect directly to register en pins.
- Reset (async, any cycle, including mid-vector-op):
  - FSM goes to IDLE; vec_cnt = 0; wait_cnt = 0; imem_timeout = 0.
  - While rst = 1: StallF = StallD = StallE = 1, FlushD = FlushE = 0, vec_busy = 0.
- Vector FSM, states IDLE and BUSY:
  - IDLE → BUSY when VecStartE & ~BranchTakenE & VEC_LAT > 1; vec_cnt loads VEC_LAT-2.
  - BUSY: vec_cnt decrements each cycle; BUSY → IDLE when vec_cnt == 0.
  - Resulting occupancy: Execute is held for exactly VEC_LAT-1 extra cycles.
  - VecStartE is ignored while in BUSY.
  - With VEC_LAT = 1 the FSM never leaves IDLE.
  - vec_busy = (state == BUSY), registered output.
- Combinational terms, zero-cycle latency from inputs:
  - ld = MemtoRegE & RegWriteE & (WA3E == Ra1D | WA3E == Ra2D) & ~BranchTakenE. A taken branch masks load-use because Decode is being flushed anyway.
  - pcw = PCSrcD | PCSrcE | PCSrcM.
  - holdE = vec_busy.
  - holdD = ld | holdE.
  - holdF = ld | pcw | holdE | ~imem_ready.
- Output equations:
  - StallE = ~holdE.
  - StallD = ~holdD.
  - StallF = ~holdF.
  - FlushE = (ld | BranchTakenE) & ~holdE.
  - FlushD = (pcw | PCSrcW | BranchTakenE | ~imem_ready) & ~holdD.
- Priority:
  - vec_busy overrides all flushes; no stage is cleared while Execute is held.
  - BranchTakenE overrides load-use.
  - imem wait bubbles Decode only when Decode is not itself held.
- Wait counter:
  - wait_cnt counts consecutive cycles with imem_ready = 0 and saturates at TIMEOUT.
  - wait_cnt clears on any cycle with imem_ready = 1.
  - imem_timeout sets on the clock edge where wait_cnt reaches TIMEOUT. It stays set until rst.
  - imem_timeout does not alter the stall/flush outputs.
- Register-zero matching is not special-cased: WA3E == 0 with RegWriteE still counts as a hazard.

Test Plan:
- Load-use: MemtoRegE = 1, RegWriteE = 1, WA3E = 5, Ra2D = 5, imem_ready = 1 → StallF = 0, StallD = 0, FlushE = 1, FlushD = 0 for that cycle only. Ra2D = 6 → all enables 1, no flush.
- Branch plus load-use in the same cycle: BranchTakenE = 1 with the hazard above → StallD = 1, FlushD = 1, FlushE = 1, StallF = 1.
- Vector op, VEC_LAT = 4: pulse VecStartE for 1 cycle → vec_busy = 1 for exactly 3 cycles starting the next cycle; StallE = StallD = StallF = 0 throughout; FlushD = FlushE = 0 even if BranchTakenE = 1; then the FSM returns to IDLE.
- Reset mid-vector: assert rst during the 2nd busy cycle → vec_busy = 0 immediately (async). After release, a new VecStartE gives a full 3-cycle busy window.
- PC write: PCSrcE = 1 → StallF = 0, FlushD = 1. PCSrcW = 1 alone → StallF = 1, FlushD = 1.
- imem wait, TIMEOUT = 16: hold imem_ready = 0 for 16 cycles → StallF = 0 and FlushD = 1 each cycle; imem_timeout rises after the 16th edge and stays 1 after imem_ready returns to 1. A 15-cycle wait leaves imem_timeout = 0.
